// File: rtl/pipeline_scoreboard_if.sv
// -----------------------------------------------------------------------------
// pipeline_scoreboard_if
// Bundles the decode-side request, the writeback notification, the flush
// strobe and the scoreboard's status outputs.
//   master : pipeline control (drives decode/writeback/flush, reads status)
//   slave  : the scoreboard itself
// Signals:
//   dec_*            instruction currently held in decode
//   wb_*             register being written back this cycle
//   flush            squash all in-flight tracking
//   stall / bubble   hold fetch+decode / insert NOP into decode/register latch
//   int_busy/fp_busy per-register pending-write bits
//   fp_unit_busy     fp execute unit occupied
//   stall_count      saturating count of stalled cycles
// -----------------------------------------------------------------------------
interface pipeline_scoreboard_if;
    logic        dec_valid;
    logic [4:0]  dec_read_addr_a;
    logic [4:0]  dec_read_addr_b;
    logic        dec_read_a_fp;
    logic        dec_read_b_fp;
    logic        dec_read_a_en;
    logic        dec_read_b_en;
    logic [4:0]  dec_write_addr;
    logic        dec_int_write_enable;
    logic        dec_fp_write_enable;
    logic [4:0]  wb_write_addr;
    logic        wb_int_write_enable;
    logic        wb_fp_write_enable;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic [31:0] int_busy;
    logic [31:0] fp_busy;
    logic        fp_unit_busy;
    logic [15:0] stall_count;

    modport master (
        output dec_valid, dec_read_addr_a, dec_read_addr_b,
               dec_read_a_fp, dec_read_b_fp, dec_read_a_en, dec_read_b_en,
               dec_write_addr, dec_int_write_enable, dec_fp_write_enable,
               wb_write_addr, wb_int_write_enable, wb_fp_write_enable, flush,
        input  stall, bubble, int_busy, fp_busy, fp_unit_busy, stall_count
    );

    modport slave (
        input  dec_valid, dec_read_addr_a, dec_read_addr_b,
               dec_read_a_fp, dec_read_b_fp, dec_read_a_en, dec_read_b_en,
               dec_write_addr, dec_int_write_enable, dec_fp_write_enable,
               wb_write_addr, wb_int_write_enable, wb_fp_write_enable, flush,
        output stall, bubble, int_busy, fp_busy, fp_unit_busy, stall_count
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// -----------------------------------------------------------------------------
// pipeline_scoreboard
// Tracks pending register writes for the int and fp register files and the
// occupancy of the multi-cycle fp execute unit, and stalls decode on RAW,
// WAW and fp-unit structural hazards.
// Ports:
//   i_clk    core clock, all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   io_sb    scoreboard interface (slave side), see pipeline_scoreboard_if
// Parameter:
//   FP_LAT   cycles the fp unit stays occupied per fp-writing instruction,
//            legal 1..15 (fits the 4-bit occupancy counter)
// -----------------------------------------------------------------------------
module pipeline_scoreboard #(
    parameter int unsigned FP_LAT = 3
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    pipeline_scoreboard_if.slave io_sb
);

    localparam logic [3:0] FP_LAT_CNT = 4'(FP_LAT);

    logic [31:0] r_int_busy;
    logic [31:0] r_fp_busy;
    logic [3:0]  r_fp_cnt;
    logic [15:0] r_stall_count;

    logic [31:0] w_int_wb_clr;
    logic [31:0] w_fp_wb_clr;
    logic [31:0] w_dest_onehot;
    logic [31:0] w_int_eff;
    logic [31:0] w_fp_eff;
    logic [31:0] w_int_set;
    logic [31:0] w_fp_set;
    logic        w_raw_a;
    logic        w_raw_b;
    logic        w_waw;
    logic        w_struct;
    logic        w_stall;
    logic        w_issue;

    // Per-register decode of the writeback and destination addresses.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            assign w_int_wb_clr[gi]  = io_sb.wb_int_write_enable &&
                                       (io_sb.wb_write_addr == 5'(gi));
            assign w_fp_wb_clr[gi]   = io_sb.wb_fp_write_enable &&
                                       (io_sb.wb_write_addr == 5'(gi));
            assign w_dest_onehot[gi] = (io_sb.dec_write_addr == 5'(gi));
        end
    endgenerate

    // A writeback landing this cycle already satisfies a dependent, so the
    // hazard check looks through it instead of waiting an extra cycle.
    assign w_int_eff = r_int_busy & ~w_int_wb_clr;
    assign w_fp_eff  = r_fp_busy  & ~w_fp_wb_clr;

    // x0 is hardwired zero and can never be pending.
    assign w_raw_a = io_sb.dec_read_a_en &&
                     (io_sb.dec_read_a_fp ? w_fp_eff[io_sb.dec_read_addr_a]
                                          : ((io_sb.dec_read_addr_a != 5'd0) &&
                                             w_int_eff[io_sb.dec_read_addr_a]));
    assign w_raw_b = io_sb.dec_read_b_en &&
                     (io_sb.dec_read_b_fp ? w_fp_eff[io_sb.dec_read_addr_b]
                                          : ((io_sb.dec_read_addr_b != 5'd0) &&
                                             w_int_eff[io_sb.dec_read_addr_b]));

    assign w_waw = (io_sb.dec_int_write_enable && (io_sb.dec_write_addr != 5'd0) &&
                    w_int_eff[io_sb.dec_write_addr]) ||
                   (io_sb.dec_fp_write_enable && w_fp_eff[io_sb.dec_write_addr]);

    assign w_struct = io_sb.dec_fp_write_enable && (r_fp_cnt != 4'd0);

    // Gated by reset so the outputs are quiet while reset is held, even if
    // the upstream logic is asserting flush.
    assign w_stall = i_rst_n && io_sb.dec_valid && (w_raw_a || w_raw_b || w_waw || w_struct) &&
                     !io_sb.flush;
    assign w_issue = io_sb.dec_valid && !w_stall && !io_sb.flush;

    assign w_int_set = (w_issue && io_sb.dec_int_write_enable && (io_sb.dec_write_addr != 5'd0))
                       ? w_dest_onehot : 32'd0;
    assign w_fp_set  = (w_issue && io_sb.dec_fp_write_enable) ? w_dest_onehot : 32'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int_busy    <= 32'd0;
            r_fp_busy     <= 32'd0;
            r_fp_cnt      <= 4'd0;
            r_stall_count <= 16'd0;
        end else begin
            if (io_sb.flush) begin
                r_int_busy <= 32'd0;
                r_fp_busy  <= 32'd0;
                r_fp_cnt   <= 4'd0;
            end else begin
                // New issue to the same register wins over its writeback.
                r_int_busy <= ((r_int_busy & ~w_int_wb_clr) | w_int_set) & ~32'd1;
                r_fp_busy  <= (r_fp_busy & ~w_fp_wb_clr) | w_fp_set;
                if (w_issue && io_sb.dec_fp_write_enable) begin
                    r_fp_cnt <= FP_LAT_CNT;
                end else if (r_fp_cnt != 4'd0) begin
                    r_fp_cnt <= r_fp_cnt - 4'd1;
                end
            end
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign io_sb.stall        = w_stall;
    assign io_sb.bubble       = i_rst_n && (w_stall || io_sb.flush);
    assign io_sb.int_busy     = r_int_busy;
    assign io_sb.fp_busy      = r_fp_busy;
    assign io_sb.fp_unit_busy = (r_fp_cnt != 4'd0);
    assign io_sb.stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
module tb_pipeline_scoreboard;
    localparam int FP_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vec_count = 0;
    int   err_count = 0;

    // Reference state: pending flags per register, remaining fp occupancy,
    // stall counter.
    bit m_int [32];
    bit m_fp  [32];
    int m_fpcnt;
    int m_scnt;

    pipeline_scoreboard_if sb ();

    pipeline_scoreboard #(.FP_LAT(FP_LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_sb   (sb)
    );

    always #5 clk = ~clk;

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_int[i] = 0;
            m_fp[i]  = 0;
        end
        m_fpcnt = 0;
    endfunction

    function automatic bit m_pending(bit fp, int a);
        if (fp)
            return m_fp[a] && !(sb.wb_fp_write_enable && int'(sb.wb_write_addr) == a);
        if (a == 0)
            return 0;
        return m_int[a] && !(sb.wb_int_write_enable && int'(sb.wb_write_addr) == a);
    endfunction

    function automatic bit m_stall();
        bit haz = 0;
        if (sb.dec_read_a_en && m_pending(sb.dec_read_a_fp, int'(sb.dec_read_addr_a))) haz = 1;
        if (sb.dec_read_b_en && m_pending(sb.dec_read_b_fp, int'(sb.dec_read_addr_b))) haz = 1;
        if (sb.dec_int_write_enable && m_pending(0, int'(sb.dec_write_addr))) haz = 1;
        if (sb.dec_fp_write_enable && m_pending(1, int'(sb.dec_write_addr))) haz = 1;
        if (sb.dec_fp_write_enable && m_fpcnt > 0) haz = 1;
        return sb.dec_valid && haz && !sb.flush;
    endfunction

    function automatic logic [31:0] m_vec(bit fp);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = fp ? m_fp[i] : m_int[i];
        return v;
    endfunction

    // Applies one clock edge worth of scoreboard rules to the model.
    function automatic void m_step();
        bit st    = m_stall();
        bit issue = sb.dec_valid && !st && !sb.flush;
        int wa    = int'(sb.dec_write_addr);
        int wb    = int'(sb.wb_write_addr);
        if (st && m_scnt < 65535) m_scnt++;
        if (sb.flush) begin
            m_clear();
        end else begin
            if (sb.wb_int_write_enable) m_int[wb] = 0;
            if (sb.wb_fp_write_enable)  m_fp[wb]  = 0;
            if (issue && sb.dec_int_write_enable && wa != 0) m_int[wa] = 1;
            if (issue && sb.dec_fp_write_enable) m_fp[wa] = 1;
            if (issue && sb.dec_fp_write_enable) m_fpcnt = FP_LAT;
            else if (m_fpcnt > 0) m_fpcnt--;
        end
    endfunction

    task automatic advance();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb.dec_valid = 0;
        sb.dec_read_addr_a = 0;  sb.dec_read_addr_b = 0;
        sb.dec_read_a_fp = 0;    sb.dec_read_b_fp = 0;
        sb.dec_read_a_en = 0;    sb.dec_read_b_en = 0;
        sb.dec_write_addr = 0;
        sb.dec_int_write_enable = 0; sb.dec_fp_write_enable = 0;
        sb.wb_write_addr = 0;
        sb.wb_int_write_enable = 0;  sb.wb_fp_write_enable = 0;
        sb.flush = 0;
    endtask

    task automatic test_reset();
        idle();
        sb.flush = 1;
        #2 rst_n = 0;
        #1;
        vec_count++;
        if ({sb.stall, sb.bubble, sb.fp_unit_busy} !== 3'b000 || sb.int_busy !== 32'd0 ||
            sb.fp_busy !== 32'd0 || sb.stall_count !== 16'd0) begin
            err_count++;
            $display("FAIL reset: stall=%b bubble=%b fpu=%b ib=%h fb=%h sc=%0d, want all 0",
                     sb.stall, sb.bubble, sb.fp_unit_busy, sb.int_busy, sb.fp_busy, sb.stall_count);
        end
        m_clear();
        m_scnt = 0;
        sb.flush = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        $display("reset: outputs checked while held");
    endtask

    task automatic test_raw_int();
        idle();
        sb.dec_valid = 1; sb.dec_int_write_enable = 1; sb.dec_write_addr = 5;
        @(negedge clk);
        vec_count++;
        if (sb.stall !== 1'b0) begin
            err_count++; $display("FAIL raw_issue: stall=%b want 0", sb.stall);
        end
        advance();
        idle();
        sb.dec_valid = 1; sb.dec_read_a_en = 1; sb.dec_read_addr_a = 5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_count++;
            if (sb.stall !== 1'b1 || sb.bubble !== 1'b1 || sb.int_busy[5] !== 1'b1) begin
                err_count++;
                $display("FAIL raw_hold[%0d]: stall=%b bubble=%b busy5=%b want 1 1 1",
                         i, sb.stall, sb.bubble, sb.int_busy[5]);
            end
            advance();
        end
        sb.wb_int_write_enable = 1; sb.wb_write_addr = 5;
        @(negedge clk);
        vec_count++;
        if (sb.stall !== 1'b0 || sb.bubble !== 1'b0) begin
            err_count++;
            $display("FAIL raw_wb_release: stall=%b bubble=%b want 0 0", sb.stall, sb.bubble);
        end
        advance();
        idle();
        @(negedge clk);
        vec_count++;
        if (sb.int_busy[5] !== 1'b0) begin
            err_count++; $display("FAIL raw_cleared: busy5=%b want 0", sb.int_busy[5]);
        end
        $display("raw_int: x5 dependency stalled 3 cycles, released on wb");
        advance();
    endtask

    task automatic test_x0();
        idle();
        sb.dec_valid = 1; sb.dec_int_write_enable = 1; sb.dec_write_addr = 0;
        advance();
        idle();
        sb.dec_valid = 1; sb.dec_read_a_en = 1; sb.dec_read_addr_a = 0;
        sb.dec_int_write_enable = 1; sb.dec_write_addr = 0;
        @(negedge clk);
        vec_count++;
        if (sb.int_busy !== 32'd0 || sb.stall !== 1'b0) begin
            err_count++;
            $display("FAIL x0: ib=%h stall=%b want 0 0", sb.int_busy, sb.stall);
        end
        $display("x0: write/read of x0 caused no hazard");
        advance();
    endtask

    task automatic test_fp_struct();
        int base;
        idle();
        sb.dec_valid = 1; sb.dec_fp_write_enable = 1; sb.dec_write_addr = 1;
        advance();
        sb.dec_write_addr = 2;
        base = m_scnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_count++;
            if (sb.stall !== 1'b1 || sb.fp_unit_busy !== 1'b1) begin
                err_count++;
                $display("FAIL fp_struct[%0d]: stall=%b fpu=%b want 1 1", i, sb.stall, sb.fp_unit_busy);
            end
            advance();
        end
        @(negedge clk);
        vec_count++;
        if (sb.stall !== 1'b0 || sb.fp_unit_busy !== 1'b0) begin
            err_count++;
            $display("FAIL fp_issue: stall=%b fpu=%b want 0 0", sb.stall, sb.fp_unit_busy);
        end
        advance();
        idle();
        @(negedge clk);
        vec_count++;
        if (sb.stall_count !== 16'(base + 3) || sb.fp_busy[2:1] !== 2'b11) begin
            err_count++;
            $display("FAIL fp_count: sc=%0d fb21=%b want %0d 11", sb.stall_count, sb.fp_busy[2:1], base + 3);
        end
        $display("fp_struct: second fp write waited 3 cycles");
        advance();
    endtask

    task automatic test_wb_issue_same();
        idle();
        sb.dec_valid = 1; sb.dec_int_write_enable = 1; sb.dec_write_addr = 7;
        advance();
        sb.wb_int_write_enable = 1; sb.wb_write_addr = 7;
        @(negedge clk);
        vec_count++;
        if (sb.stall !== 1'b0) begin
            err_count++; $display("FAIL wb_same_stall: stall=%b want 0", sb.stall);
        end
        advance();
        idle();
        @(negedge clk);
        vec_count++;
        if (sb.int_busy[7] !== 1'b1) begin
            err_count++; $display("FAIL wb_same_set: busy7=%b want 1", sb.int_busy[7]);
        end
        $display("wb_issue_same: x7 stays busy after simultaneous wb+issue");
        advance();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 4; i++) advance();
        sb.dec_valid = 1; sb.dec_int_write_enable = 1; sb.dec_write_addr = 3;
        advance();
        sb.dec_int_write_enable = 0; sb.dec_fp_write_enable = 1; sb.dec_write_addr = 4;
        advance();
        sb.dec_fp_write_enable = 0; sb.dec_int_write_enable = 1; sb.dec_write_addr = 3;
        sb.flush = 1;
        @(negedge clk);
        vec_count++;
        if (sb.bubble !== 1'b1 || sb.stall !== 1'b0 || sb.int_busy[3] !== 1'b1 ||
            sb.fp_busy[4] !== 1'b1) begin
            err_count++;
            $display("FAIL flush_cycle: bubble=%b stall=%b b3=%b f4=%b want 1 0 1 1",
                     sb.bubble, sb.stall, sb.int_busy[3], sb.fp_busy[4]);
        end
        advance();
        idle();
        @(negedge clk);
        vec_count++;
        if (sb.int_busy !== 32'd0 || sb.fp_busy !== 32'd0 || sb.fp_unit_busy !== 1'b0) begin
            err_count++;
            $display("FAIL flush_after: ib=%h fb=%h fpu=%b want 0", sb.int_busy, sb.fp_busy, sb.fp_unit_busy);
        end
        $display("flush: all tracking cleared");
        advance();
    endtask

    task automatic test_random(int n);
        int bad = 0;
        for (int c = 0; c < n; c++) begin
            int w;
            sb.dec_valid       = ($urandom_range(0, 3) != 0);
            sb.dec_read_addr_a = 5'($urandom_range(0, 7));
            sb.dec_read_addr_b = 5'($urandom_range(0, 7));
            sb.dec_read_a_fp   = 1'($urandom_range(0, 1));
            sb.dec_read_b_fp   = 1'($urandom_range(0, 1));
            sb.dec_read_a_en   = 1'($urandom_range(0, 1));
            sb.dec_read_b_en   = 1'($urandom_range(0, 1));
            sb.dec_write_addr  = 5'($urandom_range(0, 7));
            w = $urandom_range(0, 2);
            sb.dec_int_write_enable = (w == 1);
            sb.dec_fp_write_enable  = (w == 2);
            sb.wb_write_addr = 5'($urandom_range(0, 7));
            w = $urandom_range(0, 2);
            sb.wb_int_write_enable = (w == 1);
            sb.wb_fp_write_enable  = (w == 2);
            sb.flush = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            vec_count++;
            if (sb.stall !== m_stall() || sb.bubble !== (m_stall() || sb.flush) ||
                sb.int_busy !== m_vec(0) || sb.fp_busy !== m_vec(1) ||
                sb.fp_unit_busy !== (m_fpcnt > 0) || sb.stall_count !== 16'(m_scnt)) begin
                err_count++;
                bad++;
                $display("FAIL random[%0d]: stall=%b/%b bubble=%b ib=%h/%h fb=%h/%h fpu=%b/%b sc=%0d/%0d (got/want)",
                         c, sb.stall, m_stall(), sb.bubble, sb.int_busy, m_vec(0), sb.fp_busy, m_vec(1),
                         sb.fp_unit_busy, (m_fpcnt > 0), sb.stall_count, m_scnt);
            end
            advance();
        end
        $display("random: %0d cycles compared, %0d bad", n, bad);
    endtask

    task automatic test_saturate_reset();
        idle();
        sb.flush = 1;
        advance();
        idle();
        sb.dec_valid = 1; sb.dec_int_write_enable = 1; sb.dec_write_addr = 9;
        advance();
        idle();
        sb.dec_valid = 1; sb.dec_read_a_en = 1; sb.dec_read_addr_a = 9;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        @(negedge clk);
        vec_count++;
        if (sb.stall_count !== 16'hFFFF || sb.stall !== 1'b1) begin
            err_count++;
            $display("FAIL saturate: sc=%0d stall=%b want 65535 1", sb.stall_count, sb.stall);
        end
        #2 rst_n = 0;
        #1;
        vec_count++;
        if ({sb.stall, sb.bubble, sb.fp_unit_busy} !== 3'b000 || sb.int_busy !== 32'd0 ||
            sb.fp_busy !== 32'd0 || sb.stall_count !== 16'd0) begin
            err_count++;
            $display("FAIL reset_mid_stall: stall=%b bubble=%b ib=%h sc=%0d want all 0",
                     sb.stall, sb.bubble, sb.int_busy, sb.stall_count);
        end
        $display("saturate_reset: counter saturated, reset cleared outputs");
        idle();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        m_clear();
        m_scnt = 0;
        test_reset();
        test_raw_int();
        test_x0();
        test_fp_struct();
        test_wb_issue_same();
        test_flush();
        test_random(3000);
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameter FP_LAT, default 3, sets the cycles the fp execute unit is occupied per fp-writing instruction (legal range 1..15).
REQ-002 clock  input  1  single core clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dec_valid  input  1  decode stage holds a valid instruction.
REQ-005 dec_read_addr_a / dec_read_addr_b  input  5 each  source register addresses.
REQ-006 dec_read_a_fp / dec_read_b_fp  input  1 each  source is in the fp file (1) or the int file (0).
REQ-007 dec_read_a_en / dec_read_b_en  input  1 each  source operand is actually used.
REQ-008 dec_write_addr  input  5  destination register address.
REQ-009 dec_int_write_enable / dec_fp_write_enable  input  1 each  destination file select; never both 1.
REQ-010 wb_write_addr  input  5  address being written back this cycle.
REQ-011 wb_int_write_enable / wb_fp_write_enable  input  1 each  writeback to int / fp file this cycle.
REQ-012 flush  input  1  squash all in-flight tracking.
REQ-013 stall  output  1  hold fetch and fetch/decode latch contents.
REQ-014 bubble  output  1  load a NOP into the decode/register latch this cycle.
REQ-015 int_busy / fp_busy  output  32 each  per-register pending-write bits.
REQ-016 fp_unit_busy  output  1  fp execute counter non-zero.
REQ-017 stall_count  output  16  saturating count of stalled cycles.

Function
REQ-018 The effective busy bit SHALL be busy & ~(same-cycle wb clear for that file/address), so a writeback releases a dependent in the same cycle.
REQ-019 RAW hazard SHALL be: an enabled source whose effective busy bit in the selected file is 1.
REQ-020 WAW hazard SHALL be: the destination's effective busy bit in the selected file is 1.
REQ-021 Structural hazard SHALL be: dec_fp_write_enable=1 and fp_cnt != 0.
REQ-022 stall SHALL equal dec_valid & (RAW | WAW | structural) & ~flush, combinationally.
REQ-023 bubble SHALL equal stall | flush.
REQ-024 Issue SHALL occur when dec_valid=1, stall=0 and flush=0.
REQ-025 On issue with int write to a nonzero address, int_busy[addr] SHALL be set at the next edge.
REQ-026 Int register 0 SHALL never be busy; reads of and writes to int address 0 never cause hazards.
REQ-027 On issue with fp write, fp_busy[addr] SHALL be set and fp_cnt loaded with FP_LAT at the next edge.
REQ-028 fp_cnt SHALL decrement by 1 per cycle while non-zero and not reloaded; fp_unit_busy = (fp_cnt != 0).
REQ-029 A writeback SHALL clear the matching busy bit at the next edge; set from a simultaneous issue to the same file/address takes priority over the clear.
REQ-030 A writeback to a non-busy register SHALL leave state unchanged (no error).
REQ-031 flush SHALL clear all busy bits and fp_cnt at the next edge, overriding issue and writeback updates that cycle.
REQ-032 stall_count SHALL increment on each cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-033 While reset=0: int_busy=0, fp_busy=0, fp_cnt=0, stall_count=0, stall=0, bubble=0, fp_unit_busy=0, independent of clock.
REQ-034 Issue and counting SHALL resume on the first rising edge after reset deasserts; reset asserted mid-operation discards all pending state.

Verification
REQ-035 Issue int write to x5, next cycle decode reads x5 -> stall=1, bubble=1 until wb of x5; stall=0 in the wb cycle.
REQ-036 Issue int write to x0, then read x0 -> int_busy stays 0, no stall.
REQ-037 FP_LAT=3: two back-to-back fp writes to f1, f2 -> second stalls 3 cycles (fp_cnt 3,2,1), issues when fp_cnt=0; stall_count=3.
REQ-038 Same-cycle wb of x7 and issue writing x7 -> int_busy[7]=1 afterwards.
REQ-039 int_busy[3], fp_busy[4] set, flush=1 -> all busy bits 0, fp_cnt=0 next cycle, bubble=1 that cycle.
REQ-040 Hold a RAW stall 70000 cycles -> stall_count saturates at 65535; reset pulse low mid-stall -> all outputs 0 immediately.
